// File: rtl/coincidence_auto_aligner.sv
//------------------------------------------------------------------------------
// coincidence_auto_aligner
//
// Aligns one coincidence recorder automatically. The sequencer:
//   1. Issues the acquisition command.
//   2. Polls the recorder busy bit.
//   3. Reads the histogram of one channel.
//   4. Finds the first circular rising edge.
//   5. Reports the realignment offset.
// With COINCIDENCE_AUTO_APPLY_EN defined, a successful scan also writes the
// realign command to the recorder. Without it, the offset is only reported.
//
// Ports
//   sysClk        system clock, rising edge
//   sysReset_n    asynchronous active-low reset
//   start         one-cycle request, sampled only in IDLE
//   abort         return to IDLE at the next edge from any state
//   channel       channel to scan, latched on start
//   busy          high in every state except IDLE
//   done          one-cycle completion pulse (success or failure)
//   error         0 ok, 1 no edge, 2 acquisition timeout, 3 bad channel
//   edgeCount     rising edges found, saturating at 255
//   edgeAddr      address of the first rising edge
//   offset        (edgeAddr - EDGE_BACKOFF) mod N
//   recCsrStrobe  recorder CSR write strobe
//   recGPIO_OUT   recorder CSR write data
//   recCsr        recorder CSR readback
//
// Recorder handshake: recCsrStrobe is high for exactly one cycle per command.
// recGPIO_OUT carries the command in that same cycle and holds otherwise.
// There is no ready signal. The recorder always accepts a strobe, and its
// answer on recCsr is valid READ_LATENCY cycles later.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module coincidence_auto_aligner #(
    parameter int CHANNEL_COUNT               = 2,
    parameter int SAMPLE_CLKS_PER_COINCIDENCE = 400,
    parameter int DATA_WIDTH                  = 3,
    parameter int THRESHOLD                   = 1,
    parameter int EDGE_BACKOFF                = 2,
    parameter int READ_LATENCY                = 16,
    parameter int ACQ_TIMEOUT                 = 65535
) (
    input  logic        sysClk,
    input  logic        sysReset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  channel,
    output logic        busy,
    output logic        done,
    output logic [1:0]  error,
    output logic [7:0]  edgeCount,
    output logic [23:0] edgeAddr,
    output logic [23:0] offset,
    output logic        recCsrStrobe,
    output logic [31:0] recGPIO_OUT,
    input  logic [31:0] recCsr
);

    localparam logic [23:0] LAST_ADDR = 24'(SAMPLE_CLKS_PER_COINCIDENCE - 1);
    localparam logic [24:0] N25       = 25'(SAMPLE_CLKS_PER_COINCIDENCE);
    localparam logic [24:0] BACKOFF25 = 25'(EDGE_BACKOFF);
    localparam int          WAIT_W    = $clog2(READ_LATENCY) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);
    localparam int          POLL_W    = $clog2(ACQ_TIMEOUT) + 1;
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(ACQ_TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] THRESH = DATA_WIDTH'(THRESHOLD);

    typedef enum logic [3:0] {
        IDLE,
        ACQ_CMD,
        ACQ_WAIT,
        ACQ_POLL,
        RD_CMD,
        RD_WAIT,
        EVAL,
`ifdef COINCIDENCE_AUTO_APPLY_EN
        APPLY,
`endif
        DONE
    } alignerState;

    alignerState       state;
    logic [7:0]        chanReg;
    logic [23:0]       addr;
    logic              seeding;   // current read is the N-1 seed read
    logic              prevHigh;
    logic [WAIT_W-1:0] waitCnt;
    logic [POLL_W-1:0] pollCnt;

    // Evaluation of the bin currently presented on recCsr.
    logic        binHigh;
    logic        risingEdge;
    logic [7:0]  edgeCountNext;
    logic [23:0] edgeAddrNext;
    logic [24:0] offsetWide;
    logic [23:0] offsetNext;

    always_comb begin
        binHigh       = (recCsr[DATA_WIDTH-1:0] >= THRESH);
        risingEdge    = binHigh && !prevHigh && !seeding;
        edgeCountNext = edgeCount;
        edgeAddrNext  = edgeAddr;
        if (risingEdge) begin
            if (edgeCount != 8'hFF) edgeCountNext = edgeCount + 8'd1;
            if (edgeCount == 8'd0)  edgeAddrNext  = addr;
        end
        // Computed in 25 bits so that the wrap-around add cannot overflow.
        if ({1'b0, edgeAddrNext} >= BACKOFF25)
            offsetWide = {1'b0, edgeAddrNext} - BACKOFF25;
        else
            offsetWide = {1'b0, edgeAddrNext} + N25 - BACKOFF25;
        offsetNext = offsetWide[23:0];
    end

    // Readback bits between the busy flag and the bin value carry nothing we use.
    logic unusedBits;
    assign unusedBits = ^{recCsr[30:DATA_WIDTH], offsetWide[24]};

    always_ff @(posedge sysClk or negedge sysReset_n) begin
        if (!sysReset_n) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 2'd0;
            edgeCount    <= 8'd0;
            edgeAddr     <= 24'd0;
            offset       <= 24'd0;
            recCsrStrobe <= 1'b0;
            recGPIO_OUT  <= 32'd0;
            chanReg      <= 8'd0;
            addr         <= 24'd0;
            seeding      <= 1'b0;
            prevHigh     <= 1'b0;
            waitCnt      <= '0;
            pollCnt      <= '0;
        end else begin
            // Strobe and done are pulses. They are re-armed only where a
            // command or completion is issued.
            recCsrStrobe <= 1'b0;
            done         <= 1'b0;
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            busy <= 1'b1;
                            if (channel >= 8'(CHANNEL_COUNT)) begin
                                error <= 2'd3;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                error        <= 2'd0;
                                edgeCount    <= 8'd0;
                                edgeAddr     <= 24'd0;
                                offset       <= 24'd0;
                                chanReg      <= channel;
                                recCsrStrobe <= 1'b1;
                                recGPIO_OUT  <= {1'b1, 31'h0};
                                state        <= ACQ_CMD;
                            end
                        end
                    end
                    ACQ_CMD: begin
                        waitCnt <= '0;
                        state   <= ACQ_WAIT;
                    end
                    ACQ_WAIT: begin
                        if (waitCnt == WAIT_LAST) begin
                            pollCnt <= '0;
                            state   <= ACQ_POLL;
                        end else begin
                            waitCnt <= waitCnt + WAIT_W'(1);
                        end
                    end
                    ACQ_POLL: begin
                        if (!recCsr[31]) begin
                            // Seed read of the last bin so that an edge at
                            // address 0 is seen across the wrap.
                            addr         <= LAST_ADDR;
                            seeding      <= 1'b1;
                            recCsrStrobe <= 1'b1;
                            recGPIO_OUT  <= {chanReg, LAST_ADDR};
                            state        <= RD_CMD;
                        end else if (pollCnt == POLL_LAST) begin
                            error <= 2'd2;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            pollCnt <= pollCnt + POLL_W'(1);
                        end
                    end
                    RD_CMD: begin
                        waitCnt <= '0;
                        state   <= RD_WAIT;
                    end
                    RD_WAIT: begin
                        if (waitCnt == WAIT_LAST) state <= EVAL;
                        else                      waitCnt <= waitCnt + WAIT_W'(1);
                    end
                    EVAL: begin
                        prevHigh  <= binHigh;
                        edgeCount <= edgeCountNext;
                        edgeAddr  <= edgeAddrNext;
                        if (seeding) begin
                            seeding      <= 1'b0;
                            addr         <= 24'd0;
                            recCsrStrobe <= 1'b1;
                            recGPIO_OUT  <= {chanReg, 24'd0};
                            state        <= RD_CMD;
                        end else if (addr != LAST_ADDR) begin
                            addr         <= addr + 24'd1;
                            recCsrStrobe <= 1'b1;
                            recGPIO_OUT  <= {chanReg, addr + 24'd1};
                            state        <= RD_CMD;
                        end else if (edgeCountNext == 8'd0) begin
                            error <= 2'd1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            offset <= offsetNext;
`ifdef COINCIDENCE_AUTO_APPLY_EN
                            recCsrStrobe <= 1'b1;
                            recGPIO_OUT  <= {1'b0, 1'b1, 1'b0, 5'h0, offsetNext};
                            state        <= APPLY;
`else
                            done  <= 1'b1;
                            state <= DONE;
`endif
                        end
                    end
`ifdef COINCIDENCE_AUTO_APPLY_EN
                    APPLY: begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
`endif
                    DONE: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_coincidence_auto_aligner.sv
//------------------------------------------------------------------------------
// tb_coincidence_auto_aligner
//
// Directed bench for coincidence_auto_aligner with a small recorder model.
// The model answers acquisition commands with a busy bit and read commands
// with histogram bins. An expected-address queue scoreboards the read order
// and the bin-to-bin strobe period.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_coincidence_auto_aligner;

    localparam int N       = 400;
    localparam int RL      = 16;
    localparam int TIMEOUT = 10;
`ifdef COINCIDENCE_AUTO_APPLY_EN
    localparam bit APPLY_EN = 1'b1;
`else
    localparam bit APPLY_EN = 1'b0;
`endif

    logic        sysClk     = 1'b0;
    logic        sysReset_n = 1'b1;
    logic        start      = 1'b0;
    logic        abort      = 1'b0;
    logic [7:0]  channel    = 8'd0;
    logic        busy;
    logic        done;
    logic [1:0]  error;
    logic [7:0]  edgeCount;
    logic [23:0] edgeAddr;
    logic [23:0] offset;
    logic        recCsrStrobe;
    logic [31:0] recGPIO_OUT;
    logic [31:0] recCsr;

    int vectors     = 0;
    int miscompares = 0;

    // clock / reset
    always #5 sysClk = ~sysClk;

    coincidence_auto_aligner #(
        .CHANNEL_COUNT(2),
        .SAMPLE_CLKS_PER_COINCIDENCE(N),
        .DATA_WIDTH(3),
        .THRESHOLD(1),
        .EDGE_BACKOFF(2),
        .READ_LATENCY(RL),
        .ACQ_TIMEOUT(TIMEOUT)
    ) dut (
        .sysClk(sysClk),
        .sysReset_n(sysReset_n),
        .start(start),
        .abort(abort),
        .channel(channel),
        .busy(busy),
        .done(done),
        .error(error),
        .edgeCount(edgeCount),
        .edgeAddr(edgeAddr),
        .offset(offset),
        .recCsrStrobe(recCsrStrobe),
        .recGPIO_OUT(recGPIO_OUT),
        .recCsr(recCsr)
    );

    // recorder model
    logic [2:0]  hist [0:N-1];
    logic [23:0] rdAddr      = 24'd0;
    int          acqBusyLeft = 0;
    int          acqBusyLen  = 20;
    logic        holdBusy    = 1'b0;
    logic [7:0]  curChan     = 8'd0;
    logic [23:0] expQ [$];
    logic [23:0] expAddr;
    int cyc = 0, acqStrobes = 0, rdStrobes = 0, applyStrobes = 0, allStrobes = 0;
    int seqErrs = 0, periodErrs = 0, doneCount = 0;
    int lastRdCyc = 0, doneCyc = 0, acqCyc = 0;
    logic        prevWasRead = 1'b0;
    logic [31:0] lastApply   = 32'd0;

    always @(posedge sysClk) begin
        cyc++;
        if (done) begin
            doneCount++;
            doneCyc = cyc;
        end
        if (acqBusyLeft > 0) acqBusyLeft <= acqBusyLeft - 1;
        if (recCsrStrobe) begin
            allStrobes++;
            if (recGPIO_OUT == 32'h8000_0000) begin
                acqStrobes++;
                acqCyc = cyc;
                acqBusyLeft <= acqBusyLen;
                prevWasRead = 1'b0;
            end else if (recGPIO_OUT[31:24] == 8'h40) begin
                applyStrobes++;
                lastApply   = recGPIO_OUT;
                prevWasRead = 1'b0;
            end else begin
                rdStrobes++;
                rdAddr <= recGPIO_OUT[23:0];
                if (expQ.size() == 0) begin
                    seqErrs++;
                end else begin
                    expAddr = expQ.pop_front();
                    if (expAddr !== recGPIO_OUT[23:0] || recGPIO_OUT[31:24] !== curChan) seqErrs++;
                end
                if (prevWasRead && (cyc - lastRdCyc) != RL + 2) periodErrs++;
                lastRdCyc   = cyc;
                prevWasRead = 1'b1;
            end
        end
    end

    assign recCsr = {holdBusy || (acqBusyLeft > 0), 28'h0, hist[rdAddr]};

    // checking and driver tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
            $error("miscompare on %s", tag);
        end
    endtask

    task automatic fillHist(input int lo, input int hi, input logic [2:0] val);
        for (int a = lo; a <= hi; a++) hist[a] = val;
    endtask

    task automatic loadExpQ();
        expQ.delete();
        expQ.push_back(24'(N - 1));
        for (int a = 0; a < N; a++) expQ.push_back(24'(a));
    endtask

    task automatic pulseStart(input logic [7:0] chan);
        @(negedge sysClk);
        channel = chan;
        start   = 1'b1;
        @(negedge sysClk);
        start   = 1'b0;
    endtask

    task automatic waitDone(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge sysClk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic runScan(input string tag, input logic [7:0] chan, input logic [1:0] expErr,
                           input logic [7:0] expCount, input logic [23:0] expEdge,
                           input logic [23:0] expOff);
        int rd0, ap0, dn0, seq0, per0, expLat;
        bit seen;
        rd0  = rdStrobes;
        ap0  = applyStrobes;
        dn0  = doneCount;
        seq0 = seqErrs;
        per0 = periodErrs;
        loadExpQ();
        curChan = chan;
        pulseStart(chan);
        check($sformatf("%s_busy_rise", tag), 32'(busy), 32'd1);
        check($sformatf("%s_clear_count", tag), 32'(edgeCount), 32'd0);
        check($sformatf("%s_clear_addr", tag), 32'(edgeAddr), 32'd0);
        waitDone(8000, seen);
        check($sformatf("%s_done_seen", tag), 32'(seen), 32'd1);
        check($sformatf("%s_error", tag), 32'(error), 32'(expErr));
        check($sformatf("%s_edge_count", tag), 32'(edgeCount), 32'(expCount));
        check($sformatf("%s_edge_addr", tag), 32'(edgeAddr), 32'(expEdge));
        check($sformatf("%s_offset", tag), 32'(offset), 32'(expOff));
        @(negedge sysClk);
        check($sformatf("%s_busy_fall", tag), 32'(busy), 32'd0);
        check($sformatf("%s_done_pulses", tag), 32'(doneCount - dn0), 32'd1);
        check($sformatf("%s_read_strobes", tag), 32'(rdStrobes - rd0), 32'(N + 1));
        check($sformatf("%s_read_order", tag), 32'(seqErrs - seq0), 32'd0);
        check($sformatf("%s_reads_left", tag), 32'(expQ.size()), 32'd0);
        check($sformatf("%s_read_period", tag), 32'(periodErrs - per0), 32'd0);
        expLat = (expErr == 2'd0 && APPLY_EN) ? RL + 3 : RL + 2;
        check($sformatf("%s_done_latency", tag), 32'(doneCyc - lastRdCyc), 32'(expLat));
        if (expErr == 2'd0 && APPLY_EN) begin
            check($sformatf("%s_apply_strobes", tag), 32'(applyStrobes - ap0), 32'd1);
            check($sformatf("%s_apply_data", tag), lastApply, {8'h40, expOff});
        end else begin
            check($sformatf("%s_apply_strobes", tag), 32'(applyStrobes - ap0), 32'd0);
        end
    endtask

    // directed sequence
    initial begin
        int s0, d0, a0, r0;
        bit seen;

        // reset state
        #2 sysReset_n = 1'b0;
        repeat (3) @(negedge sysClk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_strobe", 32'(recCsrStrobe), 32'd0);
        check("rst_gpio", recGPIO_OUT, 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_edge_count", 32'(edgeCount), 32'd0);
        check("rst_edge_addr", 32'(edgeAddr), 32'd0);
        check("rst_offset", 32'(offset), 32'd0);
        sysReset_n = 1'b1;
        repeat (2) @(negedge sysClk);

        // bad channel: straight to DONE, no strobes
        s0 = allStrobes;
        pulseStart(8'd2);
        check("badch_done", 32'(done), 32'd1);
        check("badch_busy", 32'(busy), 32'd1);
        check("badch_error", 32'(error), 32'd3);
        @(negedge sysClk);
        check("badch_done_fall", 32'(done), 32'd0);
        check("badch_busy_fall", 32'(busy), 32'd0);
        repeat (5) @(negedge sysClk);
        check("badch_strobes", 32'(allStrobes - s0), 32'd0);

        // single plateau 120..199
        fillHist(0, N - 1, 3'd0);
        fillHist(120, 199, 3'd7);
        runScan("plateau", 8'd1, 2'd0, 8'd1, 24'd120, 24'd118);

        // wrapping plateau 390..399, 0..49
        fillHist(0, N - 1, 3'd0);
        fillHist(0, 49, 3'd7);
        fillHist(390, 399, 3'd7);
        runScan("wrap", 8'd0, 2'd0, 8'd1, 24'd390, 24'd388);

        // edge exactly at address 0
        fillHist(0, N - 1, 3'd0);
        fillHist(0, 49, 3'd7);
        runScan("edge0", 8'd0, 2'd0, 8'd1, 24'd0, 24'd398);

        // flat histograms: no edge
        fillHist(0, N - 1, 3'd0);
        runScan("all0", 8'd0, 2'd1, 8'd0, 24'd0, 24'd0);
        fillHist(0, N - 1, 3'd7);
        runScan("all7", 8'd1, 2'd1, 8'd0, 24'd0, 24'd0);

        // two plateaus: first edge wins
        fillHist(0, N - 1, 3'd0);
        fillHist(50, 99, 3'd7);
        fillHist(300, 349, 3'd7);
        runScan("two", 8'd0, 2'd0, 8'd2, 24'd50, 24'd48);

        // acquisition timeout
        holdBusy = 1'b1;
        a0 = acqStrobes;
        r0 = rdStrobes;
        pulseStart(8'd0);
        waitDone(200, seen);
        check("tmo_done_seen", 32'(seen), 32'd1);
        check("tmo_error", 32'(error), 32'd2);
        @(negedge sysClk);
        holdBusy = 1'b0;
        check("tmo_acq_strobes", 32'(acqStrobes - a0), 32'd1);
        check("tmo_read_strobes", 32'(rdStrobes - r0), 32'd0);
        check("tmo_poll_span", 32'(doneCyc - acqCyc), 32'(RL + 1 + TIMEOUT));

        // abort and start together: abort wins, outputs hold
        s0 = allStrobes;
        d0 = doneCount;
        @(negedge sysClk);
        channel = 8'd0;
        start   = 1'b1;
        abort   = 1'b1;
        @(negedge sysClk);
        start = 1'b0;
        abort = 1'b0;
        check("abst_busy", 32'(busy), 32'd0);
        check("abst_error_held", 32'(error), 32'd2);
        repeat (3) @(negedge sysClk);
        check("abst_strobes", 32'(allStrobes - s0), 32'd0);
        check("abst_done", 32'(doneCount - d0), 32'd0);

        // abort mid-scan
        fillHist(0, N - 1, 3'd0);
        fillHist(50, 99, 3'd7);
        loadExpQ();
        curChan = 8'd0;
        pulseStart(8'd0);
        repeat (600) @(negedge sysClk);
        d0 = doneCount;
        abort = 1'b1;
        @(negedge sysClk);
        abort = 1'b0;
        s0 = allStrobes;
        check("abort_busy", 32'(busy), 32'd0);
        repeat (100) @(negedge sysClk);
        check("abort_no_strobe", 32'(allStrobes - s0), 32'd0);
        check("abort_no_done", 32'(doneCount - d0), 32'd0);
        check("abort_idle_busy", 32'(busy), 32'd0);

        // asynchronous reset mid-scan, while a strobe is high
        fillHist(0, N - 1, 3'd0);
        fillHist(50, 99, 3'd7);
        fillHist(300, 349, 3'd7);
        loadExpQ();
        pulseStart(8'd1);
        curChan = 8'd1;
        loadExpQ();
        repeat (1200) @(negedge sysClk);
        check("rscan_edge_seen", 32'(edgeCount), 32'd1);
        for (int i = 0; i < 40 && !recCsrStrobe; i++) @(negedge sysClk);
        check("rscan_strobe_found", 32'(recCsrStrobe), 32'd1);
        #1 sysReset_n = 1'b0;
        #1;
        check("rscan_strobe", 32'(recCsrStrobe), 32'd0);
        check("rscan_busy", 32'(busy), 32'd0);
        check("rscan_gpio", recGPIO_OUT, 32'd0);
        check("rscan_edge_count", 32'(edgeCount), 32'd0);
        check("rscan_edge_addr", 32'(edgeAddr), 32'd0);
        check("rscan_offset", 32'(offset), 32'd0);
        check("rscan_error", 32'(error), 32'd0);
        check("rscan_done", 32'(done), 32'd0);
        @(negedge sysClk);
        sysReset_n = 1'b1;
        repeat (2) @(negedge sysClk);

        // final report
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed no completion, expected finish before 3 ms");
        $fatal(1, "watchdog expired");
    end

endmodule
